// File: rtl/disp_pkg.sv
// Shared types, constants and helpers for the multiplexed display scanner.
package disp_pkg;

  // One hex digit as presented to the 7-segment decoder.
  typedef logic [3:0] nibble_t;

  // Widest digit count supported by the scanner.
  localparam int MAX_DIGITS = 8;

  // All anodes off; callers slice this down to their digit count.
  localparam logic [MAX_DIGITS-1:0] DIG_OFF = '1;

  // Counter/index width for n states, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for one cycle out of every DIV.
module tick_gen
  import disp_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = idx_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; with DIV=1 cnt stays at 0 and tick is constant.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// A new value is accepted through load/ack and applied only at a frame
// boundary, so a frame never mixes old and new digits.
module disp_scan
  import disp_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int DIV      = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4*NDIGITS-1:0] value,
  input  logic                 load,
  output logic                 ack,
  output nibble_t              num,
  output logic [NDIGITS-1:0]   dig_n,
  output logic                 frame
);

  localparam int            IW       = idx_w(NDIGITS);
  localparam int            VW       = 4 * NDIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  logic               tick;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_next;
  logic [VW-1:0]      pend;
  logic               pflag;
  logic [VW-1:0]      shadow;
  logic [VW-1:0]      shadow_next;
  logic               boundary;
  logic               take;
  logic               upper_nz;
  logic               blank;
  nibble_t            nib_next;
  logic [NDIGITS-1:0] en_next;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Boundary detection, shadow bypass, and the contents of the next slot.
  always_comb begin
    // NOTE: every signal gets a default before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    boundary    = tick && (idx == LAST_IDX);
    idx_next    = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    take        = boundary && (load || pflag);
    shadow_next = shadow;
    nib_next    = '0;
    upper_nz    = 1'b0;
    en_next     = DIG_OFF[NDIGITS-1:0];

    // A load on the boundary cycle itself is newer than anything pending.
    if (boundary) begin
      if (load) begin
        shadow_next = value;
      end else if (pflag) begin
        shadow_next = pend;
      end
    end

    // Nibble for the upcoming slot, and whether it or any higher digit is non-zero.
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_next == IW'(i)) begin
        nib_next = shadow_next[4*i +: 4];
      end
      if ((IW'(i) >= idx_next) && (shadow_next[4*i +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end

    // Digit 0 always lights so a zero value still shows a single "0".
    blank = BLANK_LZ && (idx_next != '0) && !upper_nz;

    for (int i = 0; i < NDIGITS; i++) begin
      if ((idx_next == IW'(i)) && !blank) begin
        en_next[i] = 1'b0;
      end
    end
  end

  // Load/ack handshake: capture into pend, hand over to shadow at a boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend   <= '0;
      pflag  <= 1'b0;
      shadow <= '0;
      ack    <= 1'b0;
    end else begin
      if (load) begin
        pend  <= value;
        pflag <= 1'b1;
      end
      // Placed after the load capture so a boundary-cycle load is consumed here.
      if (take) begin
        shadow <= shadow_next;
        pflag  <= 1'b0;
      end
      ack <= take;
    end
  end

  // Slot sequencing and registered display outputs, advanced once per tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= LAST_IDX;
      num   <= '0;
      dig_n <= DIG_OFF[NDIGITS-1:0];
      frame <= 1'b0;
    end else begin
      frame <= boundary;
      if (tick) begin
        idx   <= idx_next;
        num   <= nib_next;
        dig_n <= en_next;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan (NDIGITS=4, DIV=4) with blanking on and off.
// Expected digit slots are queued when a value is driven and popped as the
// display walks through them.
module tb_disp_scan;

  localparam int ND = 4;
  localparam int DV = 4;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        load    = 1'b0;
  logic [15:0] value   = '0;

  logic        ack_b,   frame_b,   ack_nb,   frame_nb;
  logic [3:0]  num_b,   num_nb;
  logic [3:0]  dig_b,   dig_nb;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int ack_ref = 0;

  typedef struct {
    logic [3:0] dig_b;
    logic [3:0] dig_nb;
    logic [3:0] num;
  } slot_t;

  slot_t sb[$];

  always #5 clk = ~clk;

  disp_scan #(.NDIGITS(ND), .DIV(DV), .BLANK_LZ(1'b1)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (value),
    .load    (load),
    .ack     (ack_b),
    .num     (num_b),
    .dig_n   (dig_b),
    .frame   (frame_b)
  );

  disp_scan #(.NDIGITS(ND), .DIV(DV), .BLANK_LZ(1'b0)) dut_nb (
    .clk     (clk),
    .reset_n (reset_n),
    .value   (value),
    .load    (load),
    .ack     (ack_nb),
    .num     (num_nb),
    .dig_n   (dig_nb),
    .frame   (frame_nb)
  );

  // Count every ack pulse seen from the blanking instance.
  always @(posedge clk) begin
    if (ack_b) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected slots for one frame of value v.
  function automatic void push_frame(input logic [15:0] v);
    slot_t       s;
    logic [15:0] hi;
    for (int i = 0; i < ND; i++) begin
      hi       = v >> (4 * i);
      s.num    = hi[3:0];
      s.dig_nb = ~(4'b0001 << i);
      s.dig_b  = ((i != 0) && (hi == 16'h0)) ? 4'hF : s.dig_nb;
      sb.push_back(s);
    end
  endfunction

  task automatic load_pulse(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  // Compare the current slot against the scoreboard, then move to the next slot.
  // Optionally pulses load with v during the first cycle of the slot.
  task automatic check_slot(input bit do_load = 1'b0, input logic [15:0] v = '0);
    slot_t s;
    check("sb_nonempty", 16'(sb.size() != 0), 16'h1);
    if (sb.size() != 0) begin
      s = sb.pop_front();
      check("dig_n_blank",   dig_b,  s.dig_b);
      check("dig_n_noblank", dig_nb, s.dig_nb);
      check("num_blank",     num_b,  s.num);
      check("num_noblank",   num_nb, s.num);
    end
    if (do_load) begin
      load_pulse(v);
      step(DV - 1);
    end else begin
      step(DV);
    end
  endtask

  task automatic check_frame();
    for (int i = 0; i < ND; i++) check_slot();
  endtask

  // Step until the frame pulse is visible, bounded by a cycle budget.
  task automatic wait_frame(input string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while (!frame_b && (k < 40));
    check({tag, "_frame"}, frame_b, 16'h1);
    check({tag, "_frame_nb"}, frame_nb, 16'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while held in reset.
    step(3);
    check("rst_dig_n", dig_b, 16'hF);
    check("rst_num",   num_b, 16'h0);
    check("rst_ack",   ack_b, 16'h0);
    check("rst_frame", frame_b, 16'h0);

    // Release: three idle cycles, then digit 0 lights on the 4th edge.
    reset_n = 1'b1;
    for (int i = 0; i < DV - 1; i++) begin
      step();
      check("pre_dig_n", dig_b,   16'hF);
      check("pre_frame", frame_b, 16'h0);
    end
    step();
    check("first_frame", frame_b, 16'h1);
    check("first_ack",   ack_b,   16'h0);
    push_frame(16'h0000);
    check_frame();

    // Scan order: one load, one ack, frame repeats with the same value.
    ack_ref = ack_cnt;
    load_pulse(16'h1234);
    push_frame(16'h1234);
    push_frame(16'h1234);
    wait_frame("scan");
    check("scan_ack",    ack_b,  16'h1);
    check("scan_ack_nb", ack_nb, 16'h1);
    check_frame();
    check("scan_ack_repeat", ack_b, 16'h0);
    check_frame();
    check("scan_ack_cnt", 16'(ack_cnt), 16'(ack_ref + 1));

    // Leading-zero blanking.
    load_pulse(16'h00A0);
    push_frame(16'h00A0);
    wait_frame("blank");
    check("blank_ack", ack_b, 16'h1);
    check_frame();

    // Tear-free update: new value arrives during digit 1 of a 1234 frame.
    load_pulse(16'h1234);
    push_frame(16'h1234);
    wait_frame("tear_pre");
    check_slot();
    check_slot(1'b1, 16'hBEEF);
    push_frame(16'hBEEF);
    check_slot();
    check_slot();
    check("tear_frame", frame_b, 16'h1);
    check("tear_ack",   ack_b,   16'h1);
    check_frame();

    // Overwrite: the later load of the same frame wins, one ack.
    ack_ref = ack_cnt;
    load_pulse(16'h1111);
    step(2);
    load_pulse(16'h2222);
    push_frame(16'h2222);
    wait_frame("ovr");
    check("ovr_ack", ack_b, 16'h1);
    check_frame();
    check("ovr_ack_cnt", 16'(ack_cnt), 16'(ack_ref + 1));

    // Bypass: load sampled exactly on the boundary-tick edge.
    ack_ref = ack_cnt;
    step(ND * DV - 1);
    load_pulse(16'h3333);
    check("byp_frame", frame_b, 16'h1);
    check("byp_ack",   ack_b,   16'h1);
    push_frame(16'h3333);
    check_frame();
    push_frame(16'h3333);
    check_frame();
    check("byp_ack_cnt", 16'(ack_cnt), 16'(ack_ref + 1));

    // Reset mid-frame with a load pending: no ack, shadow back to zero.
    ack_ref = ack_cnt;
    load_pulse(16'h5555);
    step(5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dig_n", dig_b,   16'hF);
    check("mid_rst_num",   num_b,   16'h0);
    check("mid_rst_ack",   ack_b,   16'h0);
    check("mid_rst_frame", frame_b, 16'h0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < DV - 1; i++) begin
      step();
      check("mid_pre_dig_n", dig_b, 16'hF);
    end
    step();
    check("mid_frame", frame_b, 16'h1);
    check("mid_ack",   ack_b,   16'h0);
    push_frame(16'h0000);
    check_frame();
    push_frame(16'h0000);
    check_frame();
    check("mid_ack_cnt", 16'(ack_cnt), 16'(ack_ref));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
